keypad_item_entry: RTL and testbench
====================================

// Module: keypad_item_entry
// PURPOSE
//   Front-panel producer for the item-selection interface. Collects decimal keypad digits,
//   assembles them into an item address and issues it to item_select as a one-cycle
//   item_select/item_select_valid strobe. Sits between the keypad scanner and item_select.
//   Handles clear, enter, inactivity timeout and out-of-range entries.
// PARAMETERS
//   ITEM_ADDR_WIDTH  10    width of the issued item address
//   NUM_DIGITS       3     maximum decimal digits per entry (1..4)
//   TIMEOUT_CYCLES   1000  idle clocks in COLLECT before the entry is abandoned (>=2)
// PORTS
//   clk                input   1                system clock, rising edge
//   rstn               input   1                asynchronous active-low reset
//   key_code           input   4                0-9 = digit, 4'hA = CLEAR, 4'hB = ENTER, others ignored
//   key_valid          input   1                key_code is valid this cycle (one cycle per press)
//   item_select        output  ITEM_ADDR_WIDTH  issued item address, held until next issue
//   item_select_valid  output  1                one-cycle strobe: item_select is new
//   digit_count        output  3                digits accepted in the current entry
//   entry_busy         output  1                high in COLLECT
//   entry_error        output  1                high in LOCKOUT
// BEHAVIOUR
//   - Reset (rstn low, async): state=IDLE; item_select=0; item_select_valid=0; digit_count=0;
//     accumulator=0; timeout counter=0; entry_busy=0; entry_error=0. All outputs registered.
//   - Keys are sampled on the rising clk edge when key_valid=1. key_valid=0 means no key.
//   - Accumulator is ITEM_ADDR_WIDTH+4 bits wide.
//     A digit updates it as acc = acc*10 + digit.
//   - FSM states: IDLE, COLLECT, LOCKOUT.
//   - IDLE:
//     . digit -> acc=digit, digit_count=1, go to COLLECT.
//     . CLEAR, ENTER or an ignored code -> no effect.
//   - COLLECT:
//     . digit with digit_count<NUM_DIGITS -> accumulate, digit_count+1, timeout counter=0.
//     . digit with digit_count==NUM_DIGITS -> go to LOCKOUT.
//     . CLEAR -> acc=0, digit_count=0, go to IDLE. No strobe.
//     . ENTER with acc <= 2**ITEM_ADDR_WIDTH-1 -> on that edge item_select=acc[W-1:0] and
//       item_select_valid=1. The strobe is visible the cycle after ENTER is sampled and
//       lasts exactly one cycle. Then acc=0, digit_count=0, go to IDLE.
//     . ENTER with acc out of range -> go to LOCKOUT. No strobe; item_select unchanged.
//     . No key -> timeout counter+1. When it reaches TIMEOUT_CYCLES-1, acc=0, digit_count=0,
//       go to IDLE silently. The counter clears on every accepted key.
//   - LOCKOUT:
//     . entry_error=1; every key except CLEAR is ignored; no timeout.
//     . CLEAR -> entry_error=0, acc=0, digit_count=0, go to IDLE.
//   - A key in the cycle straight after an issue is accepted normally (IDLE), so strobes can
//     be back-to-back with a minimum spacing of 2 cycles (digit then ENTER).
//   - The timeout expiring on the same edge as an accepted key: the key wins.
//   - item_select_valid is never high for two consecutive cycles.
//   - Reset mid-entry discards the partial entry and drops any strobe in flight.
// TESTING
//   1. keys 2,9,1,ENTER (1 cycle apart) -> item_select=10'h123, item_select_valid high exactly
//      1 cycle, one cycle after the ENTER sample; digit_count back to 0.
//   2. keys 1,ENTER then 2,ENTER back-to-back -> two strobes, item_select=10'h001 then 10'h002;
//      item_select holds 10'h002 afterwards.
//   3. keys 5,CLEAR,ENTER -> no strobe; state IDLE; item_select keeps its previous value.
//   4. keys 1,2,3,4 (NUM_DIGITS=3) -> entry_error=1 after the 4th key; ENTER ignored;
//      CLEAR -> entry_error=0, IDLE.
//   5. key 7 then TIMEOUT_CYCLES idle cycles -> entry_busy falls, no strobe;
//      then 8,ENTER -> item_select=10'h008.
//   6. ITEM_ADDR_WIDTH=8: keys 2,5,6,ENTER -> LOCKOUT, no strobe.
//      rstn pulse mid-entry (keys 4,2) -> all outputs at their reset values, asynchronously.

Source files
------------

// File: rtl/keypad_item_entry_if.sv
// Keypad-to-item-selection bundle: key presses in, issued item address and entry status out.
// The master side is the keypad scanner; the slave side is keypad_item_entry.
interface keypad_item_entry_if #(
  parameter int ITEM_ADDR_WIDTH = 10
);
  logic [3:0]                 key_code;
  logic                       key_valid;
  logic [ITEM_ADDR_WIDTH-1:0] item_select;
  logic                       item_select_valid;
  logic [2:0]                 digit_count;
  logic                       entry_busy;
  logic                       entry_error;

  modport master (
    output key_code,
    output key_valid,
    input  item_select,
    input  item_select_valid,
    input  digit_count,
    input  entry_busy,
    input  entry_error
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output item_select,
    output item_select_valid,
    output digit_count,
    output entry_busy,
    output entry_error
  );
endinterface

// File: rtl/keypad_item_entry.sv
// Collects decimal keypad digits into an item address and issues it as a one-cycle strobe.
// Handles clear, enter, inactivity timeout and out-of-range entries (LOCKOUT until CLEAR).
module keypad_item_entry #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int NUM_DIGITS      = 3,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input logic                clk,
  input logic                rstn,
  keypad_item_entry_if.slave bus
);

  localparam int ACC_W = ITEM_ADDR_WIDTH + 4;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [ITEM_ADDR_WIDTH-1:0] sel_q, sel_d;
  logic                       sel_vld_q, sel_vld_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;

  logic                       is_digit_s;
  logic                       is_clear_s;
  logic                       is_enter_s;
  logic                       in_range_s;
  logic [ACC_W-1:0]           acc_next_s;

  // Next-state, accumulator and registered-output computation
  always_comb begin
    is_digit_s = bus.key_valid && (bus.key_code <= 4'd9);
    is_clear_s = bus.key_valid && (bus.key_code == 4'hA);
    is_enter_s = bus.key_valid && (bus.key_code == 4'hB);
    in_range_s = (acc_q[ACC_W-1:ITEM_ADDR_WIDTH] == 4'd0);
    acc_next_s = (acc_q * ACC_W'(10)) + ACC_W'(bus.key_code);

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    sel_d     = sel_q;
    sel_vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_digit_s) begin
          acc_d   = ACC_W'(bus.key_code);
          cnt_d   = 3'd1;
          tmo_d   = '0;
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COLLECT: begin
        if (is_digit_s) begin
          if (cnt_q < 3'(NUM_DIGITS)) begin
            acc_d = acc_next_s;
            cnt_d = cnt_q + 3'd1;
            tmo_d = '0;
          end else begin
            tmo_d   = '0;
            state_d = S_LOCKOUT;
          end
        end else if (is_clear_s) begin
          acc_d   = '0;
          cnt_d   = 3'd0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (is_enter_s) begin
          // An out-of-range entry locks the panel and leaves the last issued address intact
          if (in_range_s) begin
            sel_d     = acc_q[ITEM_ADDR_WIDTH-1:0];
            sel_vld_d = 1'b1;
            acc_d     = '0;
            cnt_d     = 3'd0;
            tmo_d     = '0;
            state_d   = S_IDLE;
          end else begin
            tmo_d   = '0;
            state_d = S_LOCKOUT;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          acc_d   = '0;
          cnt_d   = 3'd0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (is_clear_s) begin
          acc_d   = '0;
          cnt_d   = 3'd0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOCKOUT;
        end
      end

      default: begin
        acc_d   = '0;
        cnt_d   = 3'd0;
        tmo_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_COLLECT);
    err_d  = (state_d == S_LOCKOUT);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= 3'd0;
      tmo_q     <= '0;
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      sel_q     <= sel_d;
      sel_vld_q <= sel_vld_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.item_select       = sel_q;
  assign bus.item_select_valid = sel_vld_q;
  assign bus.digit_count       = cnt_q;
  assign bus.entry_busy        = busy_q;
  assign bus.entry_error       = err_q;

endmodule

// File: tb/tb_keypad_item_entry.sv
// Directed bench for keypad_item_entry: two instances (10-bit and 8-bit address) share one
// key stream and are checked every cycle against an integer model of the entry rules.
module tb_keypad_item_entry;

  localparam int TMO = 20;
  localparam int ND  = 3;
  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_ENT = 4'hB;

  logic clk;
  logic rstn;

  keypad_item_entry_if #(.ITEM_ADDR_WIDTH(10)) ifa ();
  keypad_item_entry_if #(.ITEM_ADDR_WIDTH(8))  ifb ();

  keypad_item_entry #(
    .ITEM_ADDR_WIDTH(10), .NUM_DIGITS(ND), .TIMEOUT_CYCLES(TMO)
  ) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa.slave)
  );

  keypad_item_entry #(
    .ITEM_ADDR_WIDTH(8), .NUM_DIGITS(ND), .TIMEOUT_CYCLES(TMO)
  ) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  // model: mode 0 = waiting for first digit, 1 = entering, 2 = locked out
  int mode[2];
  int ndig[2];
  int val[2];
  int idle[2];
  int exp_sel[2];
  int exp_stb[2];
  int nstb[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int width_of(input int i);
    return (i == 0) ? 10 : 8;
  endfunction

  task automatic cmp(input string nm, input int i, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h", nm, i, got, exp);
    end
  endtask

  task automatic check_all();
    cmp("item_select",       0, int'(ifa.item_select),       exp_sel[0]);
    cmp("item_select_valid", 0, int'(ifa.item_select_valid), exp_stb[0]);
    cmp("digit_count",       0, int'(ifa.digit_count),       ndig[0]);
    cmp("entry_busy",        0, int'(ifa.entry_busy),        int'(mode[0] == 1));
    cmp("entry_error",       0, int'(ifa.entry_error),       int'(mode[0] == 2));
    cmp("item_select",       1, int'(ifb.item_select),       exp_sel[1]);
    cmp("item_select_valid", 1, int'(ifb.item_select_valid), exp_stb[1]);
    cmp("digit_count",       1, int'(ifb.digit_count),       ndig[1]);
    cmp("entry_busy",        1, int'(ifb.entry_busy),        int'(mode[1] == 1));
    cmp("entry_error",       1, int'(ifb.entry_error),       int'(mode[1] == 2));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; ndig[i] = 0; val[i] = 0; idle[i] = 0;
      exp_sel[i] = 0; exp_stb[i] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    for (int i = 0; i < 2; i++) begin
      exp_stb[i] = 0;
      if (v && c <= 4'd9) begin
        if (mode[i] == 0) begin
          mode[i] = 1; val[i] = int'(c); ndig[i] = 1; idle[i] = 0;
        end else if (mode[i] == 1) begin
          if (ndig[i] < ND) begin
            val[i] = val[i] * 10 + int'(c); ndig[i]++; idle[i] = 0;
          end else begin
            mode[i] = 2;
          end
        end
      end else if (v && c == K_CLR) begin
        if (mode[i] != 0) begin
          mode[i] = 0; val[i] = 0; ndig[i] = 0;
        end
      end else if (v && c == K_ENT && mode[i] == 1) begin
        if (val[i] < (1 << width_of(i))) begin
          exp_sel[i] = val[i]; exp_stb[i] = 1; nstb[i]++;
          mode[i] = 0; ndig[i] = 0; val[i] = 0;
        end else begin
          mode[i] = 2;
        end
      end else if (mode[i] == 1) begin
        idle[i]++;
        if (idle[i] == TMO) begin
          mode[i] = 0; ndig[i] = 0; val[i] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [3:0] c);
    @(negedge clk);
    ifa.key_valid = v; ifa.key_code = c;
    ifb.key_valid = v; ifb.key_code = c;
    model_step(v, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic key(input logic [3:0] c);
    cyc(1'b1, c);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 4'h0);
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    ifa.key_valid = 1'b0; ifb.key_valid = 1'b0;
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    nstb[0] = 0; nstb[1] = 0;
    rstn = 1'b1;
    ifa.key_valid = 1'b0; ifa.key_code = 4'h0;
    ifb.key_valid = 1'b0; ifb.key_code = 4'h0;
    model_reset();
    #2 rstn = 1'b0;
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // 1: 2,9,1,ENTER -> 0x123 on the wide instance; narrow one locks out
    key(4'd2); key(4'd9); key(4'd1); key(K_ENT);
    cmp("pin_t1_sel", 0, exp_sel[0], 'h123);
    cmp("pin_t1_stb", 0, exp_stb[0], 1);
    cmp("pin_t1_lock", 1, mode[1], 2);
    idle_n(1);
    cmp("pin_t1_stb_drop", 0, int'(ifa.item_select_valid), 0);
    key(K_CLR);

    // 2: back-to-back issues
    key(4'd1); key(K_ENT); key(4'd2); key(K_ENT);
    idle_n(2);
    cmp("pin_t2_sel", 0, int'(ifa.item_select), 'h002);
    cmp("pin_t2_nstb", 0, nstb[0], 3);
    cmp("pin_t2_nstb", 1, nstb[1], 2);

    // 3: CLEAR abandons the entry, ENTER in idle does nothing
    key(4'd5); key(K_CLR); key(K_ENT);
    idle_n(1);
    cmp("pin_t3_sel", 0, int'(ifa.item_select), 'h002);
    cmp("pin_t3_nstb", 0, nstb[0], 3);

    // 4: too many digits -> lockout until CLEAR
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    cmp("pin_t4_err", 0, int'(ifa.entry_error), 1);
    key(K_ENT);
    cmp("pin_t4_still_err", 0, mode[0], 2);
    key(K_CLR);
    cmp("pin_t4_cleared", 0, int'(ifa.entry_error), 0);

    // 5: timeout, then a fresh entry; then key on the expiry edge wins
    key(4'd7);
    idle_n(TMO - 1);
    cmp("pin_t5_busy_before", 0, mode[0], 1);
    idle_n(1);
    cmp("pin_t5_busy_after", 0, int'(ifa.entry_busy), 0);
    key(4'd8); key(K_ENT);
    cmp("pin_t5_sel", 0, exp_sel[0], 'h008);
    key(4'd7);
    idle_n(TMO - 1);
    key(4'd8);
    cmp("pin_t5_key_wins", 0, int'(ifa.digit_count), 2);
    key(K_ENT);
    cmp("pin_t5_sel78", 0, exp_sel[0], 78);

    // 6: 256 fits 10 bits but not 8; then reset mid-entry
    key(4'd2); key(4'd5); key(4'd6); key(K_ENT);
    cmp("pin_t6_sel_wide", 0, exp_sel[0], 'h100);
    cmp("pin_t6_lock_narrow", 1, mode[1], 2);
    cmp("pin_t6_sel_narrow", 1, int'(ifb.item_select), 78);
    key(K_CLR);
    key(4'd4); key(4'd2);
    reset_mid_cycle();
    cmp("pin_t6_rst_cnt", 0, int'(ifa.digit_count), 0);
    idle_n(2);
    key(4'd3); key(K_ENT);
    idle_n(2);
    cmp("pin_t6_post_rst", 1, int'(ifb.item_select), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
